// File: rtl/host_memory_port.sv
// Host-side requester for the SRAM arbiter CPU port: turns host register strobes into a
// held-request / pulsed-complete handshake, with an auto-incrementing pointer and a one-byte read prefetch.
module host_memory_port #(
    parameter int ADDRESS_WIDTH = 17,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [1:0]               i_hostSelect,
    input  logic                     i_hostWrite,
    input  logic                     i_hostRead,
    input  logic [DATA_WIDTH-1:0]    i_hostWriteData,
    output logic [DATA_WIDTH-1:0]    o_hostReadData,
    output logic                     o_hostBusy,
    output logic [ADDRESS_WIDTH-1:0] o_memoryAddress,
    output logic                     o_memoryReadRequest,
    output logic                     o_memoryWriteRequest,
    output logic [DATA_WIDTH-1:0]    o_memoryWriteData,
    input  logic [DATA_WIDTH-1:0]    i_memoryReadData,
    input  logic                     i_memoryReadComplete,
    input  logic                     i_memoryWriteComplete
);

    // state    | meaning
    // S_IDLE   | no memory transaction; host data port usable when the buffer is valid
    // S_PREFETCH | read request held at the pointer until the read completes
    // S_WRITE  | write request held until the write completes
    typedef enum logic [1:0] {
        S_IDLE,
        S_PREFETCH,
        S_WRITE
    } state_t;

    localparam logic [1:0] SEL_ADDR_LO = 2'd0;
    localparam logic [1:0] SEL_ADDR_HI = 2'd1;
    localparam logic [1:0] SEL_CONTROL = 2'd2;
    localparam logic [1:0] SEL_DATA    = 2'd3;

    state_t                   r_state;
    state_t                   w_next_state;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic                     r_auto_inc;
    logic                     r_overrun;
    logic [DATA_WIDTH-1:0]    r_buffer;
    logic                     r_buffer_valid;
    logic [DATA_WIDTH-1:0]    r_read_data;
    logic [DATA_WIDTH-1:0]    r_write_data;

    logic                     w_busy;
    logic                     w_read_only;
    logic                     w_accept_write;
    logic                     w_data_write;
    logic                     w_data_read;
    logic                     w_dropped;
    logic                     w_read_done;
    logic                     w_write_done;
    logic [ADDRESS_WIDTH-1:0] w_addr_next;
    logic [DATA_WIDTH-1:0]    w_control;

    assign w_busy         = (r_state != S_IDLE) | ~r_buffer_valid;
    // A write strobe wins over a simultaneous read strobe.
    assign w_read_only    = i_hostRead & ~i_hostWrite;
    assign w_accept_write = i_hostWrite & ~w_busy;
    assign w_data_write   = w_accept_write & (i_hostSelect == SEL_DATA);
    assign w_data_read    = w_read_only & (i_hostSelect == SEL_DATA) & ~w_busy;
    assign w_dropped      = w_busy & (i_hostWrite | (w_read_only & (i_hostSelect == SEL_DATA)));
    assign w_read_done    = (r_state == S_PREFETCH) & i_memoryReadComplete;
    assign w_write_done   = (r_state == S_WRITE) & i_memoryWriteComplete;
    assign w_addr_next    = r_addr + 1'b1;
    assign w_control      = {r_auto_inc, r_overrun, {(DATA_WIDTH-3){1'b0}}, r_addr[ADDRESS_WIDTH-1]};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (!r_buffer_valid) begin
                    w_next_state = S_PREFETCH;
                end else if (w_data_write) begin
                    w_next_state = S_WRITE;
                end
            end
            S_PREFETCH: begin
                if (i_memoryReadComplete) begin
                    w_next_state = S_IDLE;
                end
            end
            S_WRITE: begin
                if (i_memoryWriteComplete) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_addr         <= '0;
            r_auto_inc     <= 1'b1;
            r_overrun      <= 1'b0;
            r_buffer       <= '0;
            r_buffer_valid <= 1'b0;
            r_read_data    <= '0;
            r_write_data   <= '0;
        end else begin
            if (w_dropped) begin
                r_overrun <= 1'b1;
            end

            if (w_accept_write) begin
                case (i_hostSelect)
                    SEL_ADDR_LO: begin
                        r_addr[DATA_WIDTH-1:0] <= i_hostWriteData;
                        r_buffer_valid         <= 1'b0;
                    end
                    SEL_ADDR_HI: begin
                        r_addr[2*DATA_WIDTH-1:DATA_WIDTH] <= i_hostWriteData;
                        r_buffer_valid                    <= 1'b0;
                    end
                    SEL_CONTROL: begin
                        r_addr[ADDRESS_WIDTH-1] <= i_hostWriteData[0];
                        r_auto_inc              <= i_hostWriteData[DATA_WIDTH-1];
                        r_overrun               <= 1'b0;
                        r_buffer_valid          <= 1'b0;
                    end
                    default: r_write_data <= i_hostWriteData;
                endcase
            end

            // Register reads are serviced even while a transaction is pending.
            if (w_read_only) begin
                case (i_hostSelect)
                    SEL_ADDR_LO: r_read_data <= r_addr[DATA_WIDTH-1:0];
                    SEL_ADDR_HI: r_read_data <= r_addr[2*DATA_WIDTH-1:DATA_WIDTH];
                    SEL_CONTROL: r_read_data <= w_control;
                    default: begin
                        if (w_data_read) begin
                            r_read_data <= r_buffer;
                            if (r_auto_inc) begin
                                r_addr         <= w_addr_next;
                                r_buffer_valid <= 1'b0;
                            end
                        end
                    end
                endcase
            end

            if (w_read_done) begin
                r_buffer       <= i_memoryReadData;
                r_buffer_valid <= 1'b1;
            end

            // Without auto-increment the buffer mirrors the byte just written, so it stays coherent.
            if (w_write_done) begin
                if (r_auto_inc) begin
                    r_addr         <= w_addr_next;
                    r_buffer_valid <= 1'b0;
                end else begin
                    r_buffer <= r_write_data;
                end
            end
        end
    end

    assign o_hostReadData       = r_read_data;
    assign o_hostBusy           = w_busy;
    assign o_memoryAddress      = r_addr;
    assign o_memoryReadRequest  = (r_state == S_PREFETCH);
    assign o_memoryWriteRequest = (r_state == S_WRITE);
    assign o_memoryWriteData    = r_write_data;

endmodule

// File: tb/tb_host_memory_port.sv
// Self-checking bench for host_memory_port: memory requests and host read data are
// checked against a scoreboard of expected values queued as stimulus is driven.
module tb_host_memory_port;

    typedef struct packed {
        logic        wr;
        logic [16:0] addr;
        logic [7:0]  data;
    } req_t;

    logic        clock;
    logic        reset;
    logic [1:0]  i_hostSelect;
    logic        i_hostWrite;
    logic        i_hostRead;
    logic [7:0]  i_hostWriteData;
    logic [7:0]  o_hostReadData;
    logic        o_hostBusy;
    logic [16:0] o_memoryAddress;
    logic        o_memoryReadRequest;
    logic        o_memoryWriteRequest;
    logic [7:0]  o_memoryWriteData;
    logic [7:0]  i_memoryReadData;
    logic        i_memoryReadComplete;
    logic        i_memoryWriteComplete;

    int   checks = 0;
    int   errors = 0;
    req_t req_q[$];
    logic [7:0] rd_q[$];
    logic prev_rd = 1'b0;
    logic prev_wr = 1'b0;

    host_memory_port dut (
        .clock                 (clock),
        .reset                 (reset),
        .i_hostSelect          (i_hostSelect),
        .i_hostWrite           (i_hostWrite),
        .i_hostRead            (i_hostRead),
        .i_hostWriteData       (i_hostWriteData),
        .o_hostReadData        (o_hostReadData),
        .o_hostBusy            (o_hostBusy),
        .o_memoryAddress       (o_memoryAddress),
        .o_memoryReadRequest   (o_memoryReadRequest),
        .o_memoryWriteRequest  (o_memoryWriteRequest),
        .o_memoryWriteData     (o_memoryWriteData),
        .i_memoryReadData      (i_memoryReadData),
        .i_memoryReadComplete  (i_memoryReadComplete),
        .i_memoryWriteComplete (i_memoryWriteComplete)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Request monitor: every new request must match the oldest queued expectation.
    always @(negedge clock) begin
        chk("req_exclusive", {31'd0, o_memoryReadRequest & o_memoryWriteRequest}, 32'd0);
        if ((o_memoryReadRequest && !prev_rd) || (o_memoryWriteRequest && !prev_wr)) begin
            if (req_q.size() == 0) begin
                chk("req_unexpected", 32'd1, 32'd0);
            end else begin
                req_t e;
                e = req_q.pop_front();
                chk("req_kind", {31'd0, o_memoryWriteRequest}, {31'd0, e.wr});
                chk("req_addr", {15'd0, o_memoryAddress}, {15'd0, e.addr});
                if (e.wr) chk("req_wdata", {24'd0, o_memoryWriteData}, {24'd0, e.data});
            end
        end
        prev_rd <= o_memoryReadRequest;
        prev_wr <= o_memoryWriteRequest;
    end

    task automatic expect_req(input logic wr, input logic [16:0] addr, input logic [7:0] data);
        req_t e;
        e.wr = wr;
        e.addr = addr;
        e.data = data;
        req_q.push_back(e);
    endtask

    task automatic host_write(input logic [1:0] sel, input logic [7:0] data);
        i_hostSelect = sel;
        i_hostWriteData = data;
        i_hostWrite = 1'b1;
        @(negedge clock);
        i_hostWrite = 1'b0;
    endtask

    task automatic host_read(input logic [1:0] sel, input logic [7:0] exp);
        logic [7:0] e;
        rd_q.push_back(exp);
        i_hostSelect = sel;
        i_hostRead = 1'b1;
        @(negedge clock);
        i_hostRead = 1'b0;
        e = rd_q.pop_front();
        chk($sformatf("host_read_sel%0d", sel), {24'd0, o_hostReadData}, {24'd0, e});
    endtask

    task automatic wait_req(input logic wr, input int max_cycles);
        int n;
        n = 0;
        while (((wr ? o_memoryWriteRequest : o_memoryReadRequest) !== 1'b1) && n < max_cycles) begin
            @(negedge clock);
            n++;
        end
        if (n >= max_cycles) chk(wr ? "wr_req_timeout" : "rd_req_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_complete(input logic wr, input logic [7:0] data);
        if (wr) i_memoryWriteComplete = 1'b1;
        else begin
            i_memoryReadComplete = 1'b1;
            i_memoryReadData = data;
        end
        @(negedge clock);
        i_memoryWriteComplete = 1'b0;
        i_memoryReadComplete = 1'b0;
        i_memoryReadData = 8'h00;
    endtask

    task automatic serve_read(input int delay, input logic [7:0] data);
        wait_req(1'b0, 30);
        repeat (delay) @(negedge clock);
        pulse_complete(1'b0, data);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        i_hostSelect = 2'd0;
        i_hostWrite = 1'b0;
        i_hostRead = 1'b0;
        i_hostWriteData = 8'h00;
        i_memoryReadData = 8'h00;
        i_memoryReadComplete = 1'b0;
        i_memoryWriteComplete = 1'b0;
        repeat (3) @(negedge clock);

        // Reset values, then first prefetch at address 0
        chk("rst_busy", {31'd0, o_hostBusy}, 32'd1);
        chk("rst_rdreq", {31'd0, o_memoryReadRequest}, 32'd0);
        chk("rst_addr", {15'd0, o_memoryAddress}, 32'd0);
        chk("rst_rdata", {24'd0, o_hostReadData}, 32'd0);
        expect_req(1'b0, 17'h00000, 8'h00);
        reset = 1'b0;
        @(negedge clock);
        chk("prefetch_after_reset", {31'd0, o_memoryReadRequest}, 32'd1);
        repeat (6) @(negedge clock);
        chk("busy_before_complete", {31'd0, o_hostBusy}, 32'd1);
        pulse_complete(1'b0, 8'hA5);
        chk("busy_after_prefetch", {31'd0, o_hostBusy}, 32'd0);
        chk("rdreq_after_prefetch", {31'd0, o_memoryReadRequest}, 32'd0);
        expect_req(1'b0, 17'h00001, 8'h00);
        host_read(2'd3, 8'hA5);
        chk("addr_inc_after_read", {15'd0, o_memoryAddress}, 32'h1);
        serve_read(1, 8'h11);

        // Write with wrap-around at the top of the address space
        expect_req(1'b0, 17'h000FF, 8'h00);
        host_write(2'd0, 8'hFF);
        serve_read(1, 8'h00);
        expect_req(1'b0, 17'h0FFFF, 8'h00);
        host_write(2'd1, 8'hFF);
        serve_read(1, 8'h00);
        expect_req(1'b0, 17'h1FFFF, 8'h00);
        host_write(2'd2, 8'h81);
        serve_read(2, 8'h5A);
        expect_req(1'b1, 17'h1FFFF, 8'h3C);
        host_write(2'd3, 8'h3C);
        repeat (3) @(negedge clock);
        chk("wrreq_held", {31'd0, o_memoryWriteRequest}, 32'd1);
        chk("wr_addr_stable", {15'd0, o_memoryAddress}, 32'h1FFFF);
        pulse_complete(1'b1, 8'h00);
        chk("wrreq_dropped", {31'd0, o_memoryWriteRequest}, 32'd0);
        chk("addr_wrapped", {15'd0, o_memoryAddress}, 32'h0);
        chk("rdreq_not_yet", {31'd0, o_memoryReadRequest}, 32'd0);
        expect_req(1'b0, 17'h00000, 8'h00);
        @(negedge clock);
        chk("prefetch_after_write", {31'd0, o_memoryReadRequest}, 32'd1);
        serve_read(1, 8'h99);

        // No auto-increment: written byte is served from the buffer
        expect_req(1'b0, 17'h00000, 8'h00);
        host_write(2'd2, 8'h00);
        serve_read(1, 8'h00);
        expect_req(1'b0, 17'h00010, 8'h00);
        host_write(2'd0, 8'h10);
        serve_read(1, 8'h20);
        expect_req(1'b1, 17'h00010, 8'h77);
        host_write(2'd3, 8'h77);
        wait_req(1'b1, 10);
        repeat (2) @(negedge clock);
        pulse_complete(1'b1, 8'h00);
        for (int i = 0; i < 4; i++) begin
            chk("no_prefetch_noinc", {31'd0, o_memoryReadRequest}, 32'd0);
            @(negedge clock);
        end
        chk("busy_noinc", {31'd0, o_hostBusy}, 32'd0);
        host_read(2'd3, 8'h77);
        host_read(2'd0, 8'h10);
        chk("addr_held_noinc", {15'd0, o_memoryAddress}, 32'h10);

        // Overrun: data write while busy is dropped and flagged
        expect_req(1'b0, 17'h00020, 8'h00);
        host_write(2'd0, 8'h20);
        host_write(2'd3, 8'h55);
        serve_read(1, 8'h01);
        host_read(2'd2, 8'h40);
        expect_req(1'b0, 17'h00020, 8'h00);
        host_write(2'd2, 8'h80);
        host_read(2'd2, 8'h80);
        serve_read(1, 8'h33);

        // Simultaneous strobes: write taken, read data holds
        expect_req(1'b0, 17'h00012, 8'h00);
        i_hostSelect = 2'd0;
        i_hostWriteData = 8'h12;
        i_hostWrite = 1'b1;
        i_hostRead = 1'b1;
        @(negedge clock);
        i_hostWrite = 1'b0;
        i_hostRead = 1'b0;
        chk("simul_rdata_hold", {24'd0, o_hostReadData}, 32'h80);
        chk("simul_addr", {15'd0, o_memoryAddress}, 32'h12);
        serve_read(1, 8'h00);
        host_read(2'd0, 8'h12);

        // Reset in the middle of a write; a late complete is ignored
        expect_req(1'b1, 17'h00012, 8'h44);
        host_write(2'd3, 8'h44);
        repeat (2) @(negedge clock);
        chk("wrreq_before_reset", {31'd0, o_memoryWriteRequest}, 32'd1);
        reset = 1'b1;
        @(negedge clock);
        chk("midrst_wrreq", {31'd0, o_memoryWriteRequest}, 32'd0);
        chk("midrst_rdreq", {31'd0, o_memoryReadRequest}, 32'd0);
        chk("midrst_addr", {15'd0, o_memoryAddress}, 32'd0);
        chk("midrst_rdata", {24'd0, o_hostReadData}, 32'd0);
        chk("midrst_wdata", {24'd0, o_memoryWriteData}, 32'd0);
        chk("midrst_busy", {31'd0, o_hostBusy}, 32'd1);
        expect_req(1'b0, 17'h00000, 8'h00);
        reset = 1'b0;
        @(negedge clock);
        pulse_complete(1'b1, 8'h00);
        chk("late_cpl_rdreq", {31'd0, o_memoryReadRequest}, 32'd1);
        chk("late_cpl_wrreq", {31'd0, o_memoryWriteRequest}, 32'd0);
        chk("late_cpl_busy", {31'd0, o_hostBusy}, 32'd1);
        serve_read(1, 8'h66);
        expect_req(1'b0, 17'h00001, 8'h00);
        host_read(2'd3, 8'h66);
        host_read(2'd2, 8'h80);
        serve_read(1, 8'h00);

        repeat (3) @(negedge clock);
        chk("req_queue_empty", req_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/host_memory_port.md
# host_memory_port

Host-side requester for the SRAM arbiter's CPU port. Turns single-cycle host register strobes into the arbiter's held request / pulsed-complete handshake. Keeps a 17-bit auto-incrementing address pointer and a one-byte read-prefetch buffer, so a data-port read returns immediately when the buffer is valid. Sits between the host bus decoder and the memory arbiter (memoryAddress / memoryRead* / memoryWrite* ports).

## Interface
- ADDRESS_WIDTH, 17, width of memoryAddress and the address pointer.
- DATA_WIDTH, 8, width of host and memory data.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high.
- hostSelect  in  2  register select: 0 = addr[7:0], 1 = addr[15:8], 2 = control, 3 = data port.
- hostWrite  in  1  one-cycle write strobe.
- hostRead  in  1  one-cycle read strobe.
- hostWriteData  in  8  write data.
- hostReadData  out  8  registered read data.
- hostBusy  out  1  high while a memory transaction is pending or the buffer is invalid.
- memoryAddress  out  17  request address.
- memoryReadRequest  out  1  read request; held until complete.
- memoryWriteRequest  out  1  write request; held until complete.
- memoryWriteData  out  8  write data.
- memoryReadData  in  8  read data; valid in the cycle memoryReadComplete is high.
- memoryReadComplete  in  1  one-cycle read-done pulse.
- memoryWriteComplete  in  1  one-cycle write-done pulse.

## Operation
- **Registers:**
  - address pointer addr[16:0];
  - autoInc (control bit 7);
  - overrun (control bit 6, sticky);
  - buffer[7:0] and bufferValid.
- **Control read value:** {autoInc, overrun, 5'b0, addr[16]}.
- **Reset values:**
  - addr = 0, autoInc = 1, overrun = 0, buffer = 0, bufferValid = 0, state IDLE;
  - hostReadData = 0, both requests = 0, memoryAddress = 0, memoryWriteData = 0;
  - hostBusy = 1, because hostBusy = (state != IDLE) | ~bufferValid.
- **States:**
  - IDLE → PREFETCH when bufferValid = 0.
  - IDLE → WRITE when a data-port write is accepted.
  - PREFETCH → IDLE on memoryReadComplete: buffer ← memoryReadData, bufferValid ← 1.
  - WRITE → IDLE on memoryWriteComplete.
- **Address writes (sel 0/1/2):**
  - Load the selected bits. A control write also loads autoInc and clears overrun.
  - Every address write clears bufferValid, which triggers a prefetch.
- **Data-port write:**
  - memoryWriteData ← hostWriteData, then enter WRITE.
  - On completion with autoInc = 1: addr increments and bufferValid clears.
  - On completion with autoInc = 0: buffer ← written byte and stays valid (coherent).
- **Data-port read:**
  - hostReadData ← buffer.
  - With autoInc = 1: addr increments and bufferValid clears.
  - With autoInc = 0: nothing else changes.
- **Register reads:** reads of sel 0/1/2 return current addr bytes / control. They are always serviced, even while busy.
- **Accesses while hostBusy = 1:** any write, or any sel-3 read, is dropped with no side effect except overrun ← 1.
- **Simultaneous hostRead and hostWrite:** the write is processed; the read is ignored and hostReadData holds.
- **Address arithmetic:** increment is modulo 2^17, so 0x1FFFF → 0x00000.
- **Request rules:**
  - memoryReadRequest and memoryWriteRequest are never high together.
  - memoryAddress and memoryWriteData are stable while either request is high.
  - memoryAddress = addr at all times.
- **Complete inputs:** ignored outside the matching wait state (a stray pulse in IDLE has no effect).

## Timing
- hostReadData updates at the edge after the hostRead strobe.
- **Write sequence** (strobe sampled at edge N):
  - memoryWriteRequest is high from N+1.
  - memoryWriteComplete is sampled high at edge M.
  - At M+1: request low, addr updated, state IDLE.
  - With autoInc = 1: memoryReadRequest rises at M+2 (prefetch).
- **Prefetch sequence:**
  - memoryReadRequest rises one cycle after entering PREFETCH.
  - It drops at the edge after memoryReadComplete is sampled.
  - At that same edge: buffer loaded, hostBusy falls.
- **After reset release:** first memoryReadRequest (addr 0) is high within 2 cycles.
- **Reset mid-transaction:** requests are 0 at the next edge; all outputs take their reset values; a late complete pulse is ignored.

## Test plan
- **Reset then prefetch:** release reset; model completes a read after 6 cycles with data 0xA5. Expect hostBusy 1→0 and a sel-3 read returning 0xA5. Then addr = 1 and a new memoryReadRequest at 0x00001.
- **Write with wrap-around:** write sel0 = 0xFF, sel1 = 0xFF, sel2 = 0x81, then sel3 = 0x3C. Expect memoryWriteRequest at 0x1FFFF with data 0x3C, held until complete. Then addr = 0x00000 and a prefetch at 0x00000.
- **No auto-increment:** sel2 = 0x00, addr = 0x00010; write 0x77 to sel3, then read sel3. Expect 0x77 with no memoryReadRequest, and addr still 0x10.
- **Overrun:** sel3 write while hostBusy = 1. Expect no memory request, sel2 read = 0x40 | autoInc, and a sel2 write clears bit 6.
- **Reset mid-write:** assert reset while memoryWriteRequest is high. Expect request low and all outputs at reset values next cycle; a memoryWriteComplete two cycles later changes nothing.
- **Simultaneous strobes:** hostRead and hostWrite together on sel0 with 0x12. Expect addr[7:0] = 0x12 and hostReadData unchanged.
